// File: rtl/eth_tx_pkg.sv
// Shared types for the 10G MAC TX arbiter: arbiter state encoding and the AXI-Stream beat bundle.
package eth_tx_pkg;

  localparam int AXIS_DW = 64;
  localparam int AXIS_KW = 8;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_GAP   = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [AXIS_DW-1:0] data;
    logic [AXIS_KW-1:0] keep;
    logic               last;
    logic               user;
    logic               valid;
  } axis_tx_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first requester after ptr, scanning upward with wrap.
module rr_pick #(
  parameter int NPORTS = 4,
  parameter int PW     = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
  input  logic [NPORTS-1:0] req,
  input  logic [PW-1:0]     ptr,
  output logic [PW-1:0]     gnt_id,
  output logic              any
);

  logic [PW-1:0] idx_s;

  // Scan from farthest to nearest so the nearest requester after ptr is the final assignment
  always_comb begin
    gnt_id = '0;
    idx_s  = '0;
    for (int i = NPORTS; i >= 1; i--) begin
      idx_s = PW'((int'(ptr) + i) % NPORTS);
      if (req[idx_s]) begin
        gnt_id = idx_s;
      end else begin
        gnt_id = gnt_id;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/eth_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing the 64-bit MAC TX stream among NPORTS sources.
// Optional per-port frame/error counters are built when TX_ARB_STATS_EN is defined.
module eth_tx_arbiter
  import eth_tx_pkg::*;
#(
  parameter int NPORTS     = 4,
  parameter int IFG_CYCLES = 1
) (
  input  logic                       clk156,
  input  logic                       reset,
  input  logic [NPORTS*AXIS_DW-1:0]  s_tdata,
  input  logic [NPORTS*AXIS_KW-1:0]  s_tkeep,
  input  logic [NPORTS-1:0]          s_tlast,
  input  logic [NPORTS-1:0]          s_tuser,
  input  logic [NPORTS-1:0]          s_tvalid,
  output logic [NPORTS-1:0]          s_tready,
  output logic [AXIS_DW-1:0]         m_axis_tx_tdata,
  output logic [AXIS_KW-1:0]         m_axis_tx_tkeep,
  output logic                       m_axis_tx_tlast,
  output logic                       m_axis_tx_tuser,
  output logic                       m_axis_tx_tvalid,
  input  logic                       m_axis_tx_tready,
  output logic [$clog2(NPORTS)-1:0]  grant_id,
  output logic                       busy
`ifdef TX_ARB_STATS_EN
  ,
  output logic [NPORTS*32-1:0]       frame_cnt,
  output logic [NPORTS*16-1:0]       err_cnt
`endif
);

  localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam logic [3:0] GAP_LOAD = (IFG_CYCLES > 0) ? 4'(IFG_CYCLES - 1) : 4'd0;

  arb_state_t    state_r, state_s;
  logic [PW-1:0] rr_ptr_r, rr_ptr_s;
  logic [PW-1:0] grant_id_r, grant_id_s;
  logic [3:0]    gap_cnt_r, gap_cnt_s;
  logic          busy_r;
  logic [PW-1:0] pick_id_s;
  logic          pick_any_s;
  logic          in_grant_s;
  logic          frame_end_s;
  axis_tx_t      sel_s;

  logic [AXIS_DW-1:0] data_a [NPORTS];
  logic [AXIS_KW-1:0] keep_a [NPORTS];

  for (genvar g = 0; g < NPORTS; g++) begin : g_unpack
    assign data_a[g] = s_tdata[g*AXIS_DW +: AXIS_DW];
    assign keep_a[g] = s_tkeep[g*AXIS_KW +: AXIS_KW];
  end

  rr_pick #(.NPORTS(NPORTS), .PW(PW)) u_rr_pick (
    .req    (s_tvalid),
    .ptr    (rr_ptr_r),
    .gnt_id (pick_id_s),
    .any    (pick_any_s)
  );

  // Zero-latency mux of the owning port; tlast only ends a frame when the MAC accepts it
  always_comb begin
    sel_s.data  = data_a[grant_id_r];
    sel_s.keep  = keep_a[grant_id_r];
    sel_s.last  = s_tlast[grant_id_r];
    sel_s.user  = s_tuser[grant_id_r];
    sel_s.valid = s_tvalid[grant_id_r];
  end

  assign in_grant_s  = (state_r == ARB_GRANT);
  assign frame_end_s = in_grant_s & sel_s.valid & m_axis_tx_tready & sel_s.last;

  assign m_axis_tx_tdata  = in_grant_s ? sel_s.data : {AXIS_DW{1'b0}};
  assign m_axis_tx_tkeep  = in_grant_s ? sel_s.keep : {AXIS_KW{1'b0}};
  assign m_axis_tx_tlast  = in_grant_s & sel_s.last;
  assign m_axis_tx_tuser  = in_grant_s & sel_s.user;
  assign m_axis_tx_tvalid = in_grant_s & sel_s.valid;

  // Backpressure reaches only the owning port
  always_comb begin
    s_tready = '0;
    if (in_grant_s) begin
      s_tready[grant_id_r] = m_axis_tx_tready;
    end else begin
      s_tready = '0;
    end
  end

  // Next-state logic: arbitrate in IDLE, hold through the frame, then count out the idle gap
  always_comb begin
    state_s    = state_r;
    rr_ptr_s   = rr_ptr_r;
    grant_id_s = grant_id_r;
    gap_cnt_s  = gap_cnt_r;
    case (state_r)
      ARB_IDLE: begin
        if (pick_any_s) begin
          state_s    = ARB_GRANT;
          grant_id_s = pick_id_s;
          rr_ptr_s   = pick_id_s;
        end else begin
          state_s = ARB_IDLE;
        end
      end
      ARB_GRANT: begin
        if (frame_end_s) begin
          state_s   = (IFG_CYCLES == 0) ? ARB_IDLE : ARB_GAP;
          gap_cnt_s = GAP_LOAD;
        end else begin
          state_s = ARB_GRANT;
        end
      end
      ARB_GAP: begin
        if (gap_cnt_r == 4'd0) begin
          state_s = ARB_IDLE;
        end else begin
          gap_cnt_s = gap_cnt_r - 4'd1;
        end
      end
      default: begin
        state_s = ARB_IDLE;
      end
    endcase
  end

  // Arbiter state register; rr_ptr starts at the top so the first scan begins at port 0
  always_ff @(posedge clk156 or posedge reset) begin
    if (reset) begin
      state_r    <= ARB_IDLE;
      rr_ptr_r   <= PW'(NPORTS - 1);
      grant_id_r <= '0;
      gap_cnt_r  <= 4'd0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      rr_ptr_r   <= rr_ptr_s;
      grant_id_r <= grant_id_s;
      gap_cnt_r  <= gap_cnt_s;
      busy_r     <= (state_s == ARB_GRANT);
    end
  end

  assign grant_id = grant_id_r;
  assign busy     = busy_r;

`ifdef TX_ARB_STATS_EN
  logic [31:0] frame_cnt_r [NPORTS];
  logic [15:0] err_cnt_r   [NPORTS];

  // Per-port completed frames (wrapping) and frames ending with tuser set (saturating)
  always_ff @(posedge clk156 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NPORTS; i++) begin
        frame_cnt_r[i] <= 32'd0;
        err_cnt_r[i]   <= 16'd0;
      end
    end else begin
      for (int i = 0; i < NPORTS; i++) begin
        if (frame_end_s && (grant_id_r == PW'(i))) begin
          frame_cnt_r[i] <= frame_cnt_r[i] + 32'd1;
          if (sel_s.user && (err_cnt_r[i] != 16'hFFFF)) begin
            err_cnt_r[i] <= err_cnt_r[i] + 16'd1;
          end else begin
            err_cnt_r[i] <= err_cnt_r[i];
          end
        end else begin
          frame_cnt_r[i] <= frame_cnt_r[i];
        end
      end
    end
  end

  for (genvar g = 0; g < NPORTS; g++) begin : g_stats
    assign frame_cnt[g*32 +: 32] = frame_cnt_r[g];
    assign err_cnt[g*16 +: 16]   = err_cnt_r[g];
  end
`endif

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Self-checking bench for eth_tx_arbiter: directed scenarios plus randomized traffic against a timeline model.
module tb_eth_tx_arbiter;

  localparam int NP  = 4;
  localparam int IFG = 1;

  logic              clk156;
  logic              reset;
  logic [NP*64-1:0]  s_tdata;
  logic [NP*8-1:0]   s_tkeep;
  logic [NP-1:0]     s_tlast, s_tuser, s_tvalid, s_tready;
  logic [63:0]       m_axis_tx_tdata;
  logic [7:0]        m_axis_tx_tkeep;
  logic              m_axis_tx_tlast, m_axis_tx_tuser, m_axis_tx_tvalid, m_axis_tx_tready;
  logic [1:0]        grant_id;
  logic              busy;
`ifdef TX_ARB_STATS_EN
  logic [NP*32-1:0]  frame_cnt;
  logic [NP*16-1:0]  err_cnt;
`endif

  eth_tx_arbiter #(.NPORTS(NP), .IFG_CYCLES(IFG)) dut (
    .clk156(clk156), .reset(reset),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tuser(s_tuser),
    .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_axis_tx_tdata(m_axis_tx_tdata), .m_axis_tx_tkeep(m_axis_tx_tkeep),
    .m_axis_tx_tlast(m_axis_tx_tlast), .m_axis_tx_tuser(m_axis_tx_tuser),
    .m_axis_tx_tvalid(m_axis_tx_tvalid), .m_axis_tx_tready(m_axis_tx_tready),
    .grant_id(grant_id), .busy(busy)
`ifdef TX_ARB_STATS_EN
    , .frame_cnt(frame_cnt), .err_cnt(err_cnt)
`endif
  );

  initial clk156 = 1'b0;
  always #5 clk156 = ~clk156;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  // source side
  int          flen_q [NP][$];
  int          gen_len [NP][512];
  int          cur_fid [NP], fid_next [NP], beat [NP], bub [NP];
  logic [NP-1:0] vld;
  bit          rnd_bub;
  int          rdy_mode, drop_cnt;
  int          bub_port, bub_after, bub_len;
  logic [NP-1:0] hs;
  bit          mhs_last;

  // reference model / scoreboard
  int m_owner, m_last, m_gid, m_arb_at;
  int rx_fid [NP], rx_beat [NP], done_frames [NP], err_frames [NP];
  int g_port[$], g_cyc[$];
  bit prev_busy;

  function automatic logic [63:0] beat_data(input int p, input int f, input int b);
    return {16'(p), 16'(f), 16'(b), 16'hA5C3};
  endfunction

  function automatic logic beat_user(input int f, input int b);
    return (((f * 3) + b) % 4) == 2;
  endfunction

  function automatic logic [7:0] beat_keep(input int f, input logic last);
    logic [7:0] full;
    full = 8'hFF;
    return last ? (full >> (f % 8)) : full;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    int len, b, f;
    logic lst;
    for (int p = 0; p < NP; p++) begin
      if (vld[p]) begin
        f   = cur_fid[p];
        b   = beat[p];
        len = flen_q[p][0];
        lst = (b == len - 1);
        s_tdata[p*64 +: 64] = beat_data(p, f, b);
        s_tkeep[p*8 +: 8]   = beat_keep(f, lst);
        s_tlast[p]  = lst;
        s_tuser[p]  = beat_user(f, b);
        s_tvalid[p] = 1'b1;
      end else begin
        s_tdata[p*64 +: 64] = {$urandom, $urandom};
        s_tkeep[p*8 +: 8]   = 8'($urandom);
        s_tlast[p]  = 1'($urandom);
        s_tuser[p]  = 1'($urandom);
        s_tvalid[p] = 1'b0;
      end
    end
  endtask

  task automatic add_frame(input int p, input int len);
    gen_len[p][fid_next[p] % 512] = len;
    flen_q[p].push_back(len);
    fid_next[p]++;
    if (!vld[p] && bub[p] == 0) vld[p] = 1'b1;
    drive();
  endtask

  task automatic clr_src();
    for (int p = 0; p < NP; p++) begin
      flen_q[p].delete();
      cur_fid[p] = fid_next[p];
      rx_fid[p]  = fid_next[p];
      beat[p] = 0; rx_beat[p] = 0; bub[p] = 0;
    end
    vld = '0; bub_port = -1; drop_cnt = 0;
    drive();
  endtask

  function automatic bit all_empty();
    for (int p = 0; p < NP; p++) if (flen_q[p].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // One clock: check at negedge against the model, then update sources after posedge.
  task automatic step();
    logic exp_v;
    logic [NP-1:0] exp_rdy;
    bit mhs, found;
    int q, p;
    @(negedge clk156);
    if (reset) begin
      chk("rst_mdata", m_axis_tx_tdata, 64'd0);
      chk("rst_misc", {m_axis_tx_tkeep, m_axis_tx_tlast, m_axis_tx_tuser, m_axis_tx_tvalid,
                       busy, grant_id, s_tready}, 64'd0);
      m_owner = -1; m_last = NP - 1; m_gid = 0; m_arb_at = cyc;
      for (int k = 0; k < NP; k++) begin done_frames[k] = 0; err_frames[k] = 0; end
      hs = '0; mhs_last = 1'b0; prev_busy = 1'b0;
    end else begin
      exp_v   = (m_owner >= 0) ? s_tvalid[m_owner] : 1'b0;
      exp_rdy = '0;
      if (m_owner >= 0) exp_rdy[m_owner] = m_axis_tx_tready;
      chk("m_tvalid", m_axis_tx_tvalid, exp_v);
      chk("s_tready", s_tready, exp_rdy);
      chk("busy", busy, m_owner >= 0);
      chk("grant_id", grant_id, m_gid);
      if (exp_v) begin
        chk("m_tdata", m_axis_tx_tdata, s_tdata[m_owner*64 +: 64]);
        chk("m_tkeep", m_axis_tx_tkeep, s_tkeep[m_owner*8 +: 8]);
        chk("m_tlast_user", {m_axis_tx_tlast, m_axis_tx_tuser}, {s_tlast[m_owner], s_tuser[m_owner]});
      end
      hs  = s_tvalid & s_tready;
      mhs = m_axis_tx_tvalid & m_axis_tx_tready;
      mhs_last = mhs & m_axis_tx_tlast;
      if (busy && !prev_busy) begin g_port.push_back(int'(grant_id)); g_cyc.push_back(cyc); end
      prev_busy = busy;
      if (mhs && m_owner >= 0) begin
        p = m_owner;
        chk("sb_data", m_axis_tx_tdata, beat_data(p, rx_fid[p], rx_beat[p]));
        chk("sb_last", m_axis_tx_tlast, rx_beat[p] == gen_len[p][rx_fid[p] % 512] - 1);
        rx_beat[p]++;
        if (rx_beat[p] >= gen_len[p][rx_fid[p] % 512]) begin rx_fid[p]++; rx_beat[p] = 0; end
      end
      if (m_owner >= 0) begin
        if (exp_v && m_axis_tx_tready && s_tlast[m_owner]) begin
          done_frames[m_owner]++;
          if (s_tuser[m_owner]) err_frames[m_owner]++;
          m_owner  = -1;
          m_arb_at = cyc + IFG + 1;
        end
      end else if (cyc >= m_arb_at && (|s_tvalid)) begin
        found = 1'b0;
        for (int k = 1; k <= NP; k++) begin
          q = (m_last + k) % NP;
          if (!found && s_tvalid[q]) begin m_owner = q; found = 1'b1; end
        end
        m_last = m_owner;
        m_gid  = m_owner;
      end
    end
    cyc++;
    @(posedge clk156);
    #1;
    for (int k = 0; k < NP; k++) begin
      if (vld[k] && hs[k]) begin
        beat[k]++;
        if (beat[k] == flen_q[k][0]) begin
          void'(flen_q[k].pop_front());
          cur_fid[k]++;
          beat[k] = 0;
        end
        vld[k] = 1'b0;
        if (k == bub_port && beat[k] == bub_after) begin bub[k] = bub_len; bub_port = -1; end
      end
      if (!vld[k]) begin
        if (bub[k] > 0) bub[k]--;
        else if (flen_q[k].size() > 0 && (!rnd_bub || ($urandom % 4) != 0)) vld[k] = 1'b1;
      end
    end
    case (rdy_mode)
      1: m_axis_tx_tready = ($urandom % 5) != 0;
      2: begin
        if (mhs_last) drop_cnt = 2;
        if (drop_cnt > 0) begin m_axis_tx_tready = 1'b0; drop_cnt--; end
        else m_axis_tx_tready = 1'b1;
      end
      default: m_axis_tx_tready = 1'b1;
    endcase
    drive();
  endtask

  task automatic run_done(input string tag, input int max);
    int n;
    n = 0;
    while (n < max && !(all_empty() && m_owner < 0)) begin step(); n++; end
    chk(tag, n < max, 1'b1);
    for (int k = 0; k < IFG + 2; k++) step();
  endtask

  initial begin
    reset = 1'b1;
    m_axis_tx_tready = 1'b1;
    rdy_mode = 0; rnd_bub = 1'b0; drop_cnt = 0; bub_port = -1; bub_after = 0; bub_len = 0;
    m_owner = -1; m_last = NP - 1; m_gid = 0; m_arb_at = 0; prev_busy = 1'b0;
    for (int p = 0; p < NP; p++) begin
      cur_fid[p] = 0; fid_next[p] = 0; beat[p] = 0; bub[p] = 0; rx_fid[p] = 0; rx_beat[p] = 0;
    end
    vld = '0;
    drive();
    s_tvalid = '1;
    repeat (3) step();
    s_tvalid = '0;
    #1 reset = 1'b0;
    repeat (10) step();
    chk("idle_tvalid", m_axis_tx_tvalid, 1'b0);

    // every port one 3-beat frame, port 0 a second one
    g_port.delete(); g_cyc.delete();
    for (int p = 0; p < NP; p++) add_frame(p, 3);
    add_frame(0, 3);
    run_done("A_timeout", 200);
    chk("A_ngrants", g_port.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < g_port.size()) chk("A_order", g_port[i], i % NP);
      if (i > 0 && i < g_cyc.size()) chk("A_spacing", g_cyc[i] - g_cyc[i-1], 5);
    end

    // port 2 four-beat frame, MAC withholds tready after tlast while port 1 waits
    rdy_mode = 2;
    g_port.delete(); g_cyc.delete();
    add_frame(2, 4);
    step();
    add_frame(1, 2);
    run_done("B_timeout", 200);
    chk("B_ngrants", g_port.size(), 2);
    if (g_port.size() == 2) chk("B_order", {g_port[0], g_port[1]}, {32'd2, 32'd1});

    // port 1 stalls three cycles mid-frame while port 3 requests
    rdy_mode = 0;
    g_port.delete(); g_cyc.delete();
    bub_port = 1; bub_after = 1; bub_len = 3;
    add_frame(1, 3);
    step();
    add_frame(3, 2);
    run_done("C_timeout", 200);
    chk("C_ngrants", g_port.size(), 2);
    if (g_port.size() == 2) begin
      chk("C_order", {g_port[0], g_port[1]}, {32'd1, 32'd3});
      chk("C_hold", g_cyc[1] - g_cyc[0], 8);
    end

    // async reset on beat 2 of a 5-beat frame
    add_frame(2, 5);
    for (int i = 0; i < 20 && beat[2] != 2; i++) step();
    chk("R_reach", beat[2], 2);
    #1 chk("R_pre_tvalid", m_axis_tx_tvalid, 1'b1);
    #1 reset = 1'b1;
    #1;
    chk("R_tready", s_tready, 4'd0);
    chk("R_tvalid", m_axis_tx_tvalid, 1'b0);
    clr_src();
    repeat (2) step();
    add_frame(2, 2);
    add_frame(0, 2);
    g_port.delete(); g_cyc.delete();
    reset = 1'b0;
    run_done("R_timeout", 200);
    chk("R_ngrants", g_port.size(), 2);
    if (g_port.size() == 2) chk("R_order", {g_port[0], g_port[1]}, {32'd0, 32'd2});

    // randomized traffic with bubbles and backpressure
    rdy_mode = 1; rnd_bub = 1'b1;
    for (int f = 0; f < 10; f++)
      for (int p = 0; p < NP; p++) add_frame(p, $urandom_range(1, 8));
    run_done("X_timeout", 4000);
    for (int p = 0; p < NP; p++) chk("X_frames_rx", rx_fid[p], fid_next[p]);
`ifdef TX_ARB_STATS_EN
    for (int p = 0; p < NP; p++) begin
      chk("S_frame_cnt", frame_cnt[p*32 +: 32], done_frames[p]);
      chk("S_err_cnt", err_cnt[p*16 +: 16], err_frames[p]);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
